// File: rtl/nx1_arb_mux_pkg.sv
// Shared definitions for the N:1 arbitrated registered mux.
// Mode encodings and a one-hot priority encoder.
package nx1_arb_mux_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;
    localparam logic [1:0] MODE_RR     = 2'b10;

    // Upper bound on channel count handled by prio_onehot.
    localparam int MAX_CH = 64;

    function automatic logic [MAX_CH-1:0] prio_onehot(
        input logic [MAX_CH-1:0] req
    );
        return req & (~req + MAX_CH'(1));
    endfunction

endpackage

// File: rtl/nx1_arb_mux_rr_arbiter.sv
// Grant generation for manual, fixed-priority and round-robin modes.
// Owns the round-robin pointer; advances it only on RR transfers.
module rr_arbiter
    import nx1_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic [1:0]      mode,
    input  logic [CH_W-1:0] sel,
    input  logic            advance,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]   grant_man, grant_fix, grant_rr;
    logic [MAX_CH-1:0] pe_out;
    logic              unused_pe_hi;
    logic              found;

    always_comb begin
        grant_man = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == sel) grant_man[i] = req[i];
        end
    end

    assign pe_out       = prio_onehot(MAX_CH'(req));
    assign grant_fix    = pe_out[N_CH-1:0];
    assign unused_pe_hi = ^pe_out[MAX_CH-1:N_CH];

    // Search from rr_ptr upward, wrapping modulo N_CH.
    always_comb begin
        grant_rr = '0;
        found    = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && req[idx]) begin
                grant_rr[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        case (mode)
            MODE_MANUAL: grant = grant_man;
            MODE_FIXED:  grant = grant_fix;
            default:     grant = grant_rr;
        endcase
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) grant_idx = grant_idx | CH_W'(i);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && mode[1]) begin
            if (int'(grant_idx) == N_CH - 1) rr_ptr_d = '0;
            else                             rr_ptr_d = grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/nx1_arb_mux.sv
// N-input registered mux with valid/ready on every port.
// One output register stage; arbitration lives in rr_arbiter.
module nx1_arb_mux
    import nx1_arb_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [CH_W-1:0]        sel,
    input  logic [N_CH-1:0]        s_valid,
    output logic [N_CH-1:0]        s_ready,
    input  logic [N_CH*DATA_W-1:0] s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic [CH_W-1:0]        m_chan
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CH_W-1:0]   m_chan_q, m_chan_d;
    logic [N_CH-1:0]   grant;
    logic [CH_W-1:0]   grant_idx;
    logic [DATA_W-1:0] data_sel;
    logic              load;
    logic              xfer;

    assign load = !m_valid_q || m_ready;
    assign xfer = load && (|grant) && !rst;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (s_valid),
        .mode      (mode),
        .sel       (sel),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign s_ready = rst ? '0 : ({N_CH{load}} & grant);

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            data_sel = data_sel
                     | (s_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
        end
    end

    // m_data/m_chan keep their last value when nothing is granted.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_chan_d  = m_chan_q;
        if (load) begin
            m_valid_d = |grant;
            if (|grant) begin
                m_data_d = data_sel;
                m_chan_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_chan_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_chan_q  <= m_chan_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_chan  = m_chan_q;

endmodule

// File: tb/tb_nx1_arb_mux.sv
// Directed bench for nx1_arb_mux: N_CH=4 main instance,
// N_CH=5 instance for out-of-range manual select.
module tb_nx1_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_chan;

    logic [1:0]  mode5;
    logic [2:0]  sel5;
    logic [4:0]  s_valid5;
    logic [4:0]  s_ready5;
    logic [39:0] s_data5;
    logic        m_valid5;
    logic [7:0]  m_data5;
    logic [2:0]  m_chan5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nx1_arb_mux #(.N_CH(4), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .sel     (sel),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_chan  (m_chan)
    );

    nx1_arb_mux #(.N_CH(5), .DATA_W(8)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode5),
        .sel     (sel5),
        .s_valid (s_valid5),
        .s_ready (s_ready5),
        .s_data  (s_data5),
        .m_valid (m_valid5),
        .m_ready (1'b1),
        .m_data  (m_data5),
        .m_chan  (m_chan5)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        mode     = 2'b01;
        sel      = 2'd0;
        s_valid  = 4'hF;
        s_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        m_ready  = 1'b1;
        mode5    = 2'b00;
        sel5     = 3'd7;
        s_valid5 = 5'h1F;
        s_data5  = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};

        // T1 reset
        repeat (3) tick();
        chk("t1_s_ready", 32'(s_ready), 32'h0);
        chk("t1_m_valid", 32'(m_valid), 32'h0);
        chk("t1_m_data",  32'(m_data),  32'h0);
        chk("t1_m_chan",  32'(m_chan),  32'h0);

        // T2 fixed priority
        rst     = 1'b0;
        s_valid = 4'b1010;
        s_data  = {8'h33, 8'hA2, 8'h11, 8'hA0};
        #1;
        chk("t2_s_ready", 32'(s_ready), 32'h2);
        tick();
        chk("t2_m_valid", 32'(m_valid), 32'h1);
        chk("t2_m_data",  32'(m_data),  32'h11);
        chk("t2_m_chan",  32'(m_chan),  32'h1);
        chk("t2_s_ready_hold_ch1", 32'(s_ready), 32'h2);
        s_valid = 4'b1000;
        #1;
        chk("t2_s_ready_ch3", 32'(s_ready), 32'h8);
        tick();
        chk("t2_m_data3", 32'(m_data), 32'h33);
        chk("t2_m_chan3", 32'(m_chan), 32'h3);
        s_valid = 4'b0000;
        tick();
        chk("t2_idle_valid", 32'(m_valid), 32'h0);
        chk("t2_idle_data",  32'(m_data),  32'h33);

        // T3 round-robin, all valid
        mode    = 2'b10;
        s_valid = 4'hF;
        s_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t3_m_valid", 32'(m_valid), 32'h1);
            chk("t3_m_chan",  32'(m_chan),  32'(k % 4));
            chk("t3_m_data",  32'(m_data),  32'hA0 + 32'(k % 4));
        end

        // T4 backpressure; mode 11 behaves as round-robin
        mode = 2'b11;
        tick();
        chk("t4_first_chan", 32'(m_chan), 32'h0);
        m_ready = 1'b0;
        #1;
        chk("t4_s_ready_hold", 32'(s_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_valid", 32'(m_valid), 32'h1);
            chk("t4_hold_chan",  32'(m_chan),  32'h0);
            chk("t4_hold_data",  32'(m_data),  32'hA0);
            chk("t4_hold_ready", 32'(s_ready), 32'h0);
        end
        m_ready = 1'b1;
        #1;
        chk("t4_reload_ready", 32'(s_ready), 32'h2);
        tick();
        chk("t4_reload_valid", 32'(m_valid), 32'h1);
        chk("t4_reload_chan",  32'(m_chan),  32'h1);
        chk("t4_reload_data",  32'(m_data),  32'hA1);

        // T6 reset with a held beat
        m_ready = 1'b0;
        rst     = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(m_valid), 32'h0);
        chk("t6_rst_data",  32'(m_data),  32'h0);
        rst     = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("t6_restart_ready", 32'(s_ready), 32'h1);
        tick();
        chk("t6_restart_chan0", 32'(m_chan), 32'h0);
        tick();
        chk("t6_restart_chan1", 32'(m_chan), 32'h1);

        // Round-robin wrap with sparse requests: ptr=2, only ch0/ch1
        s_valid = 4'b0011;
        tick();
        chk("rr_wrap_chan", 32'(m_chan), 32'h0);

        // T5 manual
        mode    = 2'b00;
        sel     = 2'd2;
        s_valid = 4'b0101;
        s_data  = {8'hA3, 8'hC2, 8'hA1, 8'hC0};
        #1;
        chk("t5_s_ready", 32'(s_ready), 32'h4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_m_chan", 32'(m_chan), 32'h2);
            chk("t5_m_data", 32'(m_data), 32'hC2);
        end
        sel = 2'd1;
        #1;
        chk("t5_nosel_ready", 32'(s_ready), 32'h0);
        tick();
        chk("t5_nosel_valid", 32'(m_valid), 32'h0);

        // N_CH=5 instance: sel=7 never grants, sel=4 does
        for (int k = 0; k < 3; k++) begin
            chk("t5_sel7_ready", 32'(s_ready5), 32'h0);
            chk("t5_sel7_valid", 32'(m_valid5), 32'h0);
            tick();
        end
        sel5 = 3'd4;
        #1;
        chk("t5_sel4_ready", 32'(s_ready5), 32'h10);
        tick();
        chk("t5_sel4_chan", 32'(m_chan5), 32'h4);
        chk("t5_sel4_data", 32'(m_data5), 32'hB4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
